// File: rtl/condition_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : condition_unit_pkg
// Description : Shared types and constants for the branch condition unit:
//               branch-type encoding, ARM-style condition codes and the bit
//               positions of N, Z, C, V inside the stored flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package condition_unit_pkg;

    // Branch flavours carried on br_type_i
    typedef enum logic [1:0] {
        BR_UNCOND = 2'b00,
        BR_CBZ    = 2'b01,
        BR_CBNZ   = 2'b10,
        BR_COND   = 2'b11
    } br_type_t;

    // Condition codes for B.cond
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} vector (MSB = N)
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_decode.sv
`default_nettype none
// ============================================================================
// Module      : cond_decode
// Description : Purely combinational condition-code evaluator. Maps a B.cond
//               condition code and an NZCV vector to a single taken bit.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_decode
    import condition_unit_pkg::*;
#(
    parameter int COND_LENGTH = 4,
    parameter int FLAG_COUNT  = 4
) (
    input  logic [COND_LENGTH-1:0] cond_i,
    input  logic [FLAG_COUNT-1:0]  flags_i,
    output logic                   taken_o
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags_i[FLAG_N];
    assign w_z = flags_i[FLAG_Z];
    assign w_c = flags_i[FLAG_C];
    assign w_v = flags_i[FLAG_V];

    // Evaluate the selected condition against the supplied flags
    always_comb begin
        taken_o = 1'b0;
        case (cond_i[3:0])
            COND_EQ: taken_o = w_z;
            COND_NE: taken_o = ~w_z;
            COND_HS: taken_o = w_c;
            COND_LO: taken_o = ~w_c;
            COND_MI: taken_o = w_n;
            COND_PL: taken_o = ~w_n;
            COND_VS: taken_o = w_v;
            COND_VC: taken_o = ~w_v;
            COND_HI: taken_o = w_c & ~w_z;
            COND_LS: taken_o = ~(w_c & ~w_z);
            COND_GE: taken_o = (w_n == w_v);
            COND_LT: taken_o = (w_n != w_v);
            COND_GT: taken_o = ~w_z & (w_n == w_v);
            COND_LE: taken_o = ~(~w_z & (w_n == w_v));
            COND_AL: taken_o = 1'b1;
            COND_NV: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/condition_unit.sv
`default_nettype none
// ============================================================================
// Module      : condition_unit
// Description : Branch condition unit. Keeps an NZCV register loaded from the
//               ALU and produces a registered taken decision one cycle after
//               each accepted branch request. Stall freezes everything.
// Revision    : 1.0 - initial release
// ============================================================================
module condition_unit
    import condition_unit_pkg::*;
#(
    parameter int COND_LENGTH = 4,
    parameter int FLAG_COUNT  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   negative_i,
    input  logic                   zero_i,
    input  logic                   carryout_i,
    input  logic                   overflow_i,
    input  logic                   set_flags_i,
    input  logic                   stall_i,
    input  logic                   br_valid_i,
    input  logic [1:0]             br_type_i,
    input  logic [COND_LENGTH-1:0] cond_i,
    output logic                   taken_o,
    output logic                   taken_valid_o,
    output logic [FLAG_COUNT-1:0]  flags_o
);

    logic [FLAG_COUNT-1:0] r_flags;
    logic                  r_taken;
    logic                  r_taken_valid;
    logic [FLAG_COUNT-1:0] w_alu_flags;
    logic                  w_cond_taken;
    logic                  w_decision;

    // Pack the live ALU status bits into NZCV order
    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_N] = negative_i;
        w_alu_flags[FLAG_Z] = zero_i;
        w_alu_flags[FLAG_C] = carryout_i;
        w_alu_flags[FLAG_V] = overflow_i;
    end

    // B.cond looks at the stored (pre-update) flags, never the live ones
    cond_decode #(
        .COND_LENGTH (COND_LENGTH),
        .FLAG_COUNT  (FLAG_COUNT)
    ) u_cond_decode (
        .cond_i  (cond_i),
        .flags_i (r_flags),
        .taken_o (w_cond_taken)
    );

    // Select the decision for the requested branch type
    always_comb begin
        w_decision = 1'b0;
        case (br_type_t'(br_type_i))
            BR_UNCOND: w_decision = 1'b1;
            BR_CBZ:    w_decision = zero_i;
            BR_CBNZ:   w_decision = ~zero_i;
            BR_COND:   w_decision = w_cond_taken;
            default:   w_decision = 1'b0;
        endcase
    end

    // Flag register and registered decision; stall holds every bit
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_flags       <= '0;
            r_taken       <= 1'b0;
            r_taken_valid <= 1'b0;
        end else if (!stall_i) begin
            if (set_flags_i) begin
                r_flags <= w_alu_flags;
            end
            if (br_valid_i) begin
                r_taken <= w_decision;
            end
            r_taken_valid <= br_valid_i;
        end
    end

    assign taken_o       = r_taken;
    assign taken_valid_o = r_taken_valid;
    assign flags_o       = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_condition_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_condition_unit
// Description : Self-checking bench for condition_unit: directed vector table,
//               stall and reset sequences, full cond x NZCV sweep and random
//               traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condition_unit;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       negative_i, zero_i, carryout_i, overflow_i;
    logic       set_flags_i, stall_i, br_valid_i;
    logic [1:0] br_type_i;
    logic [3:0] cond_i;
    logic       taken_o, taken_valid_o;
    logic [3:0] flags_o;

    condition_unit #(.COND_LENGTH(4), .FLAG_COUNT(4)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .negative_i    (negative_i),
        .zero_i        (zero_i),
        .carryout_i    (carryout_i),
        .overflow_i    (overflow_i),
        .set_flags_i   (set_flags_i),
        .stall_i       (stall_i),
        .br_valid_i    (br_valid_i),
        .br_type_i     (br_type_i),
        .cond_i        (cond_i),
        .taken_o       (taken_o),
        .taken_valid_o (taken_valid_o),
        .flags_o       (flags_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic       m_taken;
    logic       m_valid;

    typedef struct {
        logic       set;
        logic [3:0] nzcv;
        logic       valid;
        logic [1:0] btype;
        logic [3:0] cond;
        logic       exp_taken;
        logic       exp_valid;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions grouped in pairs: even code tests a base predicate, odd code
    // its negation, except the last pair which is always true.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if ((cc >> 1) == 7) return 1'b1;
        return cc[0] ? !base : base;
    endfunction

    task automatic drive(input logic set, input logic [3:0] nzcv, input logic valid,
                         input logic [1:0] btype, input logic [3:0] cond, input logic stall);
        set_flags_i = set;
        {negative_i, zero_i, carryout_i, overflow_i} = nzcv;
        br_valid_i  = valid;
        br_type_i   = btype;
        cond_i      = cond;
        stall_i     = stall;
    endtask

    // One clock: advance the model from the current inputs, then compare
    task automatic cycle();
        logic       nt;
        logic [3:0] live;
        live = {negative_i, zero_i, carryout_i, overflow_i};
        nt = m_taken;
        if (!stall_i) begin
            if (br_valid_i) begin
                case (br_type_i)
                    2'd0: nt = 1'b1;
                    2'd1: nt = zero_i;
                    2'd2: nt = !zero_i;
                    default: nt = ref_cond(cond_i, m_flags);
                endcase
            end
            m_taken = nt;
            m_valid = br_valid_i;
            if (set_flags_i) m_flags = live;
        end
        @(posedge clk_i);
        #1;
        check("taken", {7'd0, taken_o}, {7'd0, m_taken});
        check("taken_valid", {7'd0, taken_valid_o}, {7'd0, m_valid});
        check("flags", {4'd0, flags_o}, {4'd0, m_flags});
    endtask

    // Assert reset between edges with a request pending, check immediate clear
    task automatic mid_reset();
        drive(1'b1, 4'($urandom), 1'b1, 2'($urandom), 4'($urandom), 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst_taken", {7'd0, taken_o}, 8'd0);
        check("async_rst_valid", {7'd0, taken_valid_o}, 8'd0);
        check("async_rst_flags", {4'd0, flags_o}, 8'd0);
        m_flags = 4'd0; m_taken = 1'b0; m_valid = 1'b0;
        br_valid_i  = 1'b0;
        set_flags_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_held_valid", {7'd0, taken_valid_o}, 8'd0);
        reset_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b1000, 1'b0, 2'd0, 4'd0,     1'b0, 1'b0, 4'b1000};
        vecs[1] = '{1'b0, 4'b0000, 1'b1, 2'd3, 4'b1011,  1'b1, 1'b1, 4'b1000};
        vecs[2] = '{1'b0, 4'b0000, 1'b1, 2'd3, 4'b1010,  1'b0, 1'b1, 4'b1000};
        vecs[3] = '{1'b1, 4'b0100, 1'b1, 2'd3, 4'b0000,  1'b0, 1'b1, 4'b0100};
        vecs[4] = '{1'b0, 4'b0000, 1'b1, 2'd3, 4'b0000,  1'b1, 1'b1, 4'b0100};
        vecs[5] = '{1'b0, 4'b0100, 1'b1, 2'd1, 4'b0111,  1'b1, 1'b1, 4'b0100};
        vecs[6] = '{1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000,  1'b0, 1'b1, 4'b0100};
        vecs[7] = '{1'b0, 4'b0011, 1'b1, 2'd0, 4'b0000,  1'b1, 1'b1, 4'b0100};
        vecs[8] = '{1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000,  1'b1, 1'b0, 4'b0100};
        vecs[9] = '{1'b0, 4'b0000, 1'b1, 2'd2, 4'b0001,  1'b1, 1'b1, 4'b0100};

        reset_i = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        m_flags = 4'd0; m_taken = 1'b0; m_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_flags", {4'd0, flags_o}, 8'd0);
        check("reset_valid", {7'd0, taken_valid_o}, 8'd0);
        check("reset_taken", {7'd0, taken_o}, 8'd0);
        reset_i = 1'b0;
        cycle();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].set, vecs[i].nzcv, vecs[i].valid, vecs[i].btype, vecs[i].cond, 1'b0);
            cycle();
            check($sformatf("vec%0d_taken", i), {7'd0, taken_o}, {7'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d_valid", i), {7'd0, taken_valid_o}, {7'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_flags", i), {4'd0, flags_o}, {4'd0, vecs[i].exp_flags});
        end

        // Stall: accept a request, then freeze for three cycles with noise
        drive(1'b0, 4'b0100, 1'b1, 2'd1, 4'd0, 1'b0);
        cycle();
        check("pre_stall_taken", {7'd0, taken_o}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom), ($urandom_range(0, 1) == 1), 2'($urandom), 4'($urandom), 1'b1);
            cycle();
            check("stall_taken", {7'd0, taken_o}, 8'd1);
            check("stall_valid", {7'd0, taken_valid_o}, 8'd1);
            check("stall_flags", {4'd0, flags_o}, 8'b0100);
        end
        drive(1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        cycle();

        // Reset mid-request, then first edge behaves normally
        mid_reset();
        drive(1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        cycle();
        drive(1'b1, 4'b0010, 1'b1, 2'd0, 4'd0, 1'b0);
        cycle();

        // Exhaustive cond x NZCV sweep with a reset in the middle
        for (int f = 0; f < 16; f++) begin
            if (f == 8) mid_reset();
            drive(1'b1, 4'(f), 1'b0, 2'd0, 4'd0, 1'b0);
            cycle();
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 4'($urandom), 1'b1, 2'd3, 4'(c), 1'b0);
                cycle();
                check($sformatf("sweep_f%0d_c%0d", f, c), {7'd0, taken_o},
                      {7'd0, ref_cond(4'(c), 4'(f))});
            end
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_reset();
            end else begin
                drive(($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                      2'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/condition_unit.md
CONDITION_UNIT -- requirements
Module: condition_unit

Interface
REQ-001 SHALL have parameter COND_LENGTH, default 4, width of branch condition code.
REQ-002 SHALL have parameter FLAG_COUNT, default 4, number of stored flags (NZCV).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports negative_i, zero_i, carryout_i, overflow_i  input  1 each  status flags from the ALU for the current instruction.
REQ-006 SHALL have port set_flags_i  input  1  capture current ALU flags into NZCV register.
REQ-007 SHALL have port stall_i  input  1  freeze all state and outputs.
REQ-008 SHALL have port br_valid_i  input  1  branch evaluation request this cycle.
REQ-009 SHALL have port br_type_i  input  2  00 B unconditional, 01 CBZ, 10 CBNZ, 11 B.cond.
REQ-010 SHALL have port cond_i  input  COND_LENGTH  condition code for B.cond.
REQ-011 SHALL have port taken_o  output  1  registered branch decision.
REQ-012 SHALL have port taken_valid_o  output  1  taken_o holds a result for the request of the previous accepted cycle.
REQ-013 SHALL have port flags_o  output  FLAG_COUNT  stored {N,Z,C,V}, MSB = N.

Function
REQ-014 NZCV register SHALL load {negative_i, zero_i, carryout_i, overflow_i} on a rising edge when set_flags_i=1 and stall_i=0; otherwise hold.
REQ-015 Request SHALL be accepted on a rising edge when br_valid_i=1 and stall_i=0; taken_valid_o=1 the following cycle, latency exactly 1.
REQ-016 taken_valid_o SHALL be 0 the cycle after a non-stalled cycle with br_valid_i=0.
REQ-017 Decision: B -> 1; CBZ -> zero_i; CBNZ -> !zero_i (live ALU zero, operand passed through ALU).
REQ-018 B.cond SHALL use stored NZCV: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !(C&!Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V)); 1110 AL 1; 1111 NV 1.
REQ-019 Simultaneous set_flags_i=1 and B.cond request SHALL evaluate against pre-update NZCV; new flags visible from the next request.
REQ-020 While stall_i=1, NZCV, taken_o and taken_valid_o SHALL hold exactly; all other inputs ignored.
REQ-021 cond_i SHALL be ignored unless br_type_i=11.
REQ-022 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-023 reset_i=1 SHALL immediately (asynchronously) force NZCV=0000, taken_o=0, taken_valid_o=0.
REQ-024 Reset asserted mid-request SHALL discard the request; no taken_valid_o pulse after deassertion.
REQ-025 First accepted edge after reset deassertion SHALL behave as a normal cycle.

Structure
REQ-026 Shared package SHALL hold br_type enum (BR_UNCOND, BR_CBZ, BR_CBNZ, BR_COND), 4-bit cond-code constants (COND_EQ..COND_NV), and flag bit-index constants.
REQ-027 Condition decode (cond + NZCV -> 1 bit) SHALL be a combinational sub-module cond_decode, reused by the B.cond path.

Verification
REQ-028 Reset then flags_o read -> 0000; taken_valid_o=0 with br_valid_i=0.
REQ-029 set_flags_i=1 with N=1,V=0; next cycle B.cond cond=1011 (LT) -> taken_o=1, taken_valid_o=1 one cycle later; cond=1010 (GE) -> taken_o=0.
REQ-030 Same cycle set_flags_i=1 with Z=1 and B.cond EQ, prior Z=0 -> taken_o=0; repeat EQ next cycle -> taken_o=1.
REQ-031 CBZ with zero_i=1 -> taken_o=1; CBNZ with zero_i=1 -> 0; B with anything -> 1.
REQ-032 Request accepted, stall_i=1 for 3 cycles with toggling inputs -> taken_o, taken_valid_o, flags_o unchanged.
REQ-033 Exhaustive sweep of 16 cond codes x 16 NZCV values -> taken_o matches REQ-018 table; reset asserted between edges mid-sweep -> outputs 0 immediately.
